// File: rtl/pte_mem_pkg.sv
// Shared types and constants for the page-walker / CPU DRAM request sequencer.
package pte_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        MST_PW  = 1'b0,
        MST_CPU = 1'b1
    } mst_t;

    localparam logic [3:0] WSTRB_FULL = 4'hF;

endpackage

// File: rtl/pte_mem_slot.sv
// Single-entry request capture slot: loads on a strobe while empty, clears when the transfer finishes.
module pte_mem_slot #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    input  logic [3:0]            ld_wstrb,
    input  logic                  clr,
    output logic                  valid,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wstrb
);

    // Capture on strobe only when empty; a strobe while occupied is dropped.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            valid <= 1'b0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            wstrb <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (ld_req && !valid) begin
            valid <= 1'b1;
            we    <= ld_we;
            addr  <= ld_addr;
            wdata <= ld_wdata;
            wstrb <= ld_wstrb;
        end
    end

endmodule

// File: rtl/pte_mem_port.sv
// Serialises MMU walker PTE traffic and CPU load/store traffic onto one DRAM controller port.
module pte_mem_port
    import pte_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    input  logic                  pw_req,
    input  logic                  pw_we,
    input  logic [ADDR_WIDTH-1:0] pw_addr,
    input  logic [DATA_WIDTH-1:0] pw_wdata,
    output logic [DATA_WIDTH-1:0] pw_rdata,
    output logic                  pw_busy,
    output logic                  pw_done,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [3:0]            cpu_wstrb,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_busy,
    output logic                  dram_req,
    output logic                  dram_we,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    output logic [DATA_WIDTH-1:0] dram_wdata,
    output logic [3:0]            dram_wstrb,
    input  logic                  dram_ack,
    input  logic [DATA_WIDTH-1:0] dram_rdata,
    output logic                  err_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t                state;
    mst_t                  grant;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_inc_c;
    logic [ADDR_WIDTH-1:0] pw_addr_al_c;

    logic                  pw_s_we,    cpu_s_we;
    logic [ADDR_WIDTH-1:0] pw_s_addr,  cpu_s_addr;
    logic [DATA_WIDTH-1:0] pw_s_wdata, cpu_s_wdata;
    logic [3:0]            pw_s_wstrb, cpu_s_wstrb;
    logic                  pw_clr_c,   cpu_clr_c;

    // PTEs are word aligned; the low address bits from the walker are discarded.
    assign pw_addr_al_c = pw_addr & ~ADDR_WIDTH'(3);
    // Saturating next count, so the counter can never wrap.
    assign cnt_inc_c    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign pw_clr_c     = (state == ST_DONE) && (grant == MST_PW);
    assign cpu_clr_c    = (state == ST_DONE) && (grant == MST_CPU);

    pte_mem_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_pw_slot (
        .CLK      (CLK),
        .RST_X    (RST_X),
        .ld_req   (pw_req),
        .ld_we    (pw_we),
        .ld_addr  (pw_addr_al_c),
        .ld_wdata (pw_wdata),
        .ld_wstrb (WSTRB_FULL),
        .clr      (pw_clr_c),
        .valid    (pw_busy),
        .we       (pw_s_we),
        .addr     (pw_s_addr),
        .wdata    (pw_s_wdata),
        .wstrb    (pw_s_wstrb)
    );

    pte_mem_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_cpu_slot (
        .CLK      (CLK),
        .RST_X    (RST_X),
        .ld_req   (cpu_req),
        .ld_we    (cpu_we),
        .ld_addr  (cpu_addr),
        .ld_wdata (cpu_wdata),
        .ld_wstrb (cpu_wstrb),
        .clr      (cpu_clr_c),
        .valid    (cpu_busy),
        .we       (cpu_s_we),
        .addr     (cpu_s_addr),
        .wdata    (cpu_s_wdata),
        .wstrb    (cpu_s_wstrb)
    );

    // Sequencer: grant (walker priority, also seeing a strobe landing this cycle), issue, wait/timeout, retire.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state       <= ST_IDLE;
            grant       <= MST_PW;
            cnt         <= '0;
            pw_rdata    <= '0;
            cpu_rdata   <= '0;
            pw_done     <= 1'b0;
            err_timeout <= 1'b0;
            dram_req    <= 1'b0;
            dram_we     <= 1'b0;
            dram_addr   <= '0;
            dram_wdata  <= '0;
            dram_wstrb  <= '0;
        end else begin
            pw_done     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pw_busy || pw_req) begin
                        grant <= MST_PW;
                        cnt   <= '0;
                        state <= ST_ISSUE;
                    end else if (cpu_busy || cpu_req) begin
                        grant <= MST_CPU;
                        cnt   <= '0;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    dram_req <= 1'b1;
                    if (grant == MST_PW) begin
                        dram_we    <= pw_s_we;
                        dram_addr  <= pw_s_addr;
                        dram_wdata <= pw_s_wdata;
                        dram_wstrb <= pw_s_wstrb;
                    end else begin
                        dram_we    <= cpu_s_we;
                        dram_addr  <= cpu_s_addr;
                        dram_wdata <= cpu_s_wdata;
                        dram_wstrb <= cpu_s_wstrb;
                    end
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dram_ack) begin
                        dram_req <= 1'b0;
                        pw_done  <= (grant == MST_PW);
                        if (!dram_we) begin
                            if (grant == MST_PW) pw_rdata  <= dram_rdata;
                            else                 cpu_rdata <= dram_rdata;
                        end
                        state <= ST_DONE;
                    end else if (cnt_inc_c == CNT_MAX) begin
                        // Counter reaches the limit on this cycle: abort with zero read data.
                        cnt         <= cnt_inc_c;
                        dram_req    <= 1'b0;
                        err_timeout <= 1'b1;
                        pw_done     <= (grant == MST_PW);
                        if (!dram_we) begin
                            if (grant == MST_PW) pw_rdata  <= '0;
                            else                 cpu_rdata <= '0;
                        end
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pte_mem_port.sv
// Self-checking bench for pte_mem_port: directed scenarios followed by randomized traffic against a transaction-level model.
module tb_pte_mem_port;

    localparam int unsigned TO = 8;

    logic        CLK = 1'b0;
    logic        RST_X;
    logic        pw_req, pw_we;
    logic [31:0] pw_addr, pw_wdata, pw_rdata;
    logic        pw_busy, pw_done;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_busy;
    logic        dram_req, dram_we;
    logic [31:0] dram_addr, dram_wdata;
    logic [3:0]  dram_wstrb;
    logic        dram_ack;
    logic [31:0] dram_rdata;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    pte_mem_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST_X(RST_X),
        .pw_req(pw_req), .pw_we(pw_we), .pw_addr(pw_addr), .pw_wdata(pw_wdata),
        .pw_rdata(pw_rdata), .pw_busy(pw_busy), .pw_done(pw_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
        .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_wstrb(dram_wstrb), .dram_ack(dram_ack),
        .dram_rdata(dram_rdata), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_reqs();
        pw_req  = 1'b0;
        cpu_req = 1'b0;
    endtask

    // Wait (bounded) for dram_req; returns number of cycles waited.
    task automatic wait_req(output int n);
        n = 0;
        while (!dram_req && n < 30) begin
            tick();
            n++;
        end
        if (!dram_req) check("dram_req_wait_expired", 32'(dram_req), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pw_rdata"},  pw_rdata,          32'd0);
        check({tag, "_cpu_rdata"}, cpu_rdata,         32'd0);
        check({tag, "_dram_req"},  32'(dram_req),     32'd0);
        check({tag, "_dram_addr"}, dram_addr,         32'd0);
        check({tag, "_dram_wstrb"},32'(dram_wstrb),   32'd0);
        check({tag, "_busy"},      32'({pw_busy, cpu_busy}), 32'd0);
        check({tag, "_pulses"},    32'({pw_done, err_timeout, dram_we}), 32'd0);
    endtask

    // Model state for the randomized phase.
    logic [31:0] m_pw_rdata, m_cpu_rdata;
    logic [31:0] e_addr, e_wdata, rd;
    logic [3:0]  e_wstrb;
    logic        e_we, is_pw, go_pw, go_cpu, tmo;
    logic [31:0] r_pw_addr, r_pw_wdata, r_cpu_addr, r_cpu_wdata;
    logic        r_pw_we, r_cpu_we;
    logic [3:0]  r_cpu_wstrb;
    int          n, lat, nocyc, sel, cnt_req;
    logic        prev_req;

    initial begin
        RST_X = 1'b0;
        pw_req = 0; pw_we = 0; pw_addr = 0; pw_wdata = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
        dram_ack = 0; dram_rdata = 0;
        tick(); tick();
        check_all_zero("reset");
        RST_X = 1'b1;
        tick();

        // Walker read with ack on the first possible cycle.
        pw_req = 1; pw_we = 0; pw_addr = 32'h8000_1004;
        tick(); clear_reqs();
        check("rd_busy_n1", 32'(pw_busy), 32'd1);
        check("rd_req_n1",  32'(dram_req), 32'd0);
        tick();
        check("rd_req_n2",   32'(dram_req), 32'd1);
        check("rd_addr",     dram_addr, 32'h8000_1004);
        check("rd_we",       32'(dram_we), 32'd0);
        check("rd_wstrb",    32'(dram_wstrb), 32'hF);
        dram_ack = 1; dram_rdata = 32'h2000_00CF;
        tick(); dram_ack = 0;
        check("rd_rdata_n3", pw_rdata, 32'h2000_00CF);
        check("rd_done_n3",  32'(pw_done), 32'd1);
        check("rd_busy_n3",  32'(pw_busy), 32'd1);
        check("rd_req_n3",   32'(dram_req), 32'd0);
        tick();
        check("rd_busy_n4",  32'(pw_busy), 32'd0);
        check("rd_done_n4",  32'(pw_done), 32'd0);

        // Walker write-back with unaligned address.
        pw_req = 1; pw_we = 1; pw_addr = 32'h8000_1007; pw_wdata = 32'h2000_00CF;
        tick(); clear_reqs();
        wait_req(n);
        check("wb_addr",  dram_addr, 32'h8000_1004);
        check("wb_we",    32'(dram_we), 32'd1);
        check("wb_wstrb", 32'(dram_wstrb), 32'hF);
        check("wb_wdata", dram_wdata, 32'h2000_00CF);
        dram_ack = 1; dram_rdata = 32'hDEAD_BEEF;
        tick(); dram_ack = 0;
        check("wb_done",  32'(pw_done), 32'd1);
        check("wb_rdata_kept", pw_rdata, 32'h2000_00CF);
        tick();

        // Timeout on a walker read.
        pw_req = 1; pw_we = 0; pw_addr = 32'h0000_0040;
        tick(); clear_reqs();
        tick();
        n = 0;
        while (dram_req && n < 20) begin
            n++;
            tick();
        end
        check("to_req_cycles", 32'(n), 32'(TO));
        check("to_err",        32'(err_timeout), 32'd1);
        check("to_done",       32'(pw_done), 32'd1);
        check("to_rdata",      pw_rdata, 32'd0);
        tick();
        check("to_busy",       32'(pw_busy), 32'd0);
        check("to_err_clear",  32'(err_timeout), 32'd0);

        // Simultaneous strobes: walker first, CPU one IDLE cycle after walker DONE.
        pw_req = 1; pw_we = 0; pw_addr = 32'h0000_0100;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_0204; cpu_wdata = 32'hA5A5_5A5A; cpu_wstrb = 4'b0011;
        tick(); clear_reqs();
        wait_req(n);
        check("arb_first_addr", dram_addr, 32'h0000_0100);
        check("arb_cpu_busy",   32'(cpu_busy), 32'd1);
        dram_ack = 1; dram_rdata = 32'h1234_5678;
        tick(); dram_ack = 0;
        check("arb_pw_done", 32'(pw_done), 32'd1);
        wait_req(n);
        check("arb_gap",        32'(n), 32'd3);
        check("arb_cpu_addr",   dram_addr, 32'h0000_0204);
        check("arb_cpu_we",     32'(dram_we), 32'd1);
        check("arb_cpu_wstrb",  32'(dram_wstrb), 32'h3);
        check("arb_cpu_wdata",  dram_wdata, 32'hA5A5_5A5A);
        dram_ack = 1; dram_rdata = 32'h0BAD_0BAD;
        tick(); dram_ack = 0;
        check("arb_cpu_nodone", 32'(pw_done), 32'd0);
        tick();
        check("arb_cpu_busy_lo", 32'(cpu_busy), 32'd0);
        check("arb_pw_rdata",    pw_rdata, 32'h1234_5678);
        check("arb_cpu_rdata",   cpu_rdata, 32'd0);

        // Reset asserted while in WAIT.
        pw_req = 1; pw_we = 0; pw_addr = 32'h0000_0300;
        tick(); clear_reqs();
        tick();
        check("rst_in_wait_req", 32'(dram_req), 32'd1);
        RST_X = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge CLK); #1;
        RST_X = 1'b1;
        tick();
        pw_req = 1; pw_we = 0; pw_addr = 32'h0000_0308;
        tick(); clear_reqs();
        wait_req(n);
        check("post_rst_addr", dram_addr, 32'h0000_0308);
        dram_ack = 1; dram_rdata = 32'h5555_AAAA;
        tick(); dram_ack = 0;
        check("post_rst_done", 32'(pw_done), 32'd1);
        tick();
        check("post_rst_rdata", pw_rdata, 32'h5555_AAAA);

        // Second strobe while busy is ignored: exactly one transaction.
        pw_req = 1; pw_we = 0; pw_addr = 32'h0000_0400;
        tick();
        pw_addr = 32'h0000_0500;
        tick(); clear_reqs();
        check("dup_addr", dram_addr, 32'h0000_0400);
        dram_ack = 1; dram_rdata = 32'h0000_0777;
        tick(); dram_ack = 0;
        cnt_req = 0; prev_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dram_req && !prev_req) cnt_req++;
            prev_req = dram_req;
        end
        check("dup_extra_txn", 32'(cnt_req), 32'd0);
        check("dup_busy",      32'(pw_busy), 32'd0);

        // Randomized traffic against a transaction-level model.
        m_pw_rdata  = pw_rdata;
        m_cpu_rdata = cpu_rdata;
        for (int it = 0; it < 40; it++) begin
            sel    = int'($urandom_range(0, 2));
            go_pw  = (sel != 1);
            go_cpu = (sel != 0);
            r_pw_we = 1'($urandom); r_pw_addr = $urandom; r_pw_wdata = $urandom;
            r_cpu_we = 1'($urandom); r_cpu_addr = $urandom; r_cpu_wdata = $urandom;
            r_cpu_wstrb = 4'($urandom);
            pw_req = go_pw;   pw_we = r_pw_we;   pw_addr = r_pw_addr;   pw_wdata = r_pw_wdata;
            cpu_req = go_cpu; cpu_we = r_cpu_we; cpu_addr = r_cpu_addr; cpu_wdata = r_cpu_wdata;
            cpu_wstrb = r_cpu_wstrb;
            tick(); clear_reqs();
            for (int k = 0; k < 2; k++) begin
                is_pw = (k == 0);
                if ((is_pw && go_pw) || (!is_pw && go_cpu)) begin
                    e_we    = is_pw ? r_pw_we : r_cpu_we;
                    e_addr  = is_pw ? {r_pw_addr[31:2], 2'b00} : r_cpu_addr;
                    e_wdata = is_pw ? r_pw_wdata : r_cpu_wdata;
                    e_wstrb = is_pw ? 4'hF : r_cpu_wstrb;
                    wait_req(n);
                    check("rnd_addr",  dram_addr, e_addr);
                    check("rnd_we",    32'(dram_we), 32'(e_we));
                    check("rnd_wdata", dram_wdata, e_wdata);
                    check("rnd_wstrb", 32'(dram_wstrb), 32'(e_wstrb));
                    lat   = int'($urandom_range(0, 9));
                    tmo   = (lat >= int'(TO));
                    nocyc = tmo ? int'(TO) : lat;
                    rd    = $urandom;
                    if ($urandom_range(0, 1) == 1) begin
                        if (is_pw) begin pw_req = 1; pw_addr = $urandom; pw_we = 1'($urandom); end
                        else begin cpu_req = 1; cpu_addr = $urandom; cpu_we = 1'($urandom); end
                    end
                    for (int c = 0; c < nocyc; c++) begin
                        tick(); clear_reqs();
                    end
                    if (!tmo) begin
                        dram_ack = 1; dram_rdata = rd;
                        tick(); dram_ack = 0; clear_reqs();
                    end
                    check("rnd_err",    32'(err_timeout), 32'(tmo));
                    check("rnd_done",   32'(pw_done), 32'(is_pw));
                    check("rnd_req_lo", 32'(dram_req), 32'd0);
                    if (!e_we) begin
                        if (is_pw) m_pw_rdata  = tmo ? 32'd0 : rd;
                        else       m_cpu_rdata = tmo ? 32'd0 : rd;
                    end
                    if ($urandom_range(0, 1) == 1) begin
                        if (is_pw) pw_req = 1; else cpu_req = 1;
                    end
                    tick(); clear_reqs();
                    check("rnd_busy_lo", 32'(is_pw ? pw_busy : cpu_busy), 32'd0);
                    check("rnd_pw_rdata",  pw_rdata,  m_pw_rdata);
                    check("rnd_cpu_rdata", cpu_rdata, m_cpu_rdata);
                end
            end
            tick();
            check("rnd_idle", 32'({pw_busy, cpu_busy, dram_req}), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
